// File: rtl/m_shift_sched.sv
// Two-requester round-robin scheduler feeding a shared parallel-load, LSB-first
// serial shifter, with valid/first-bit framing and a programmable post-frame idle gap.
module m_shift_sched #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  input  logic             w_req0,
  input  logic [WIDTH-1:0] w_data0,
  input  logic             w_req1,
  input  logic [WIDTH-1:0] w_data1,
  output logic             w_gnt0,
  output logic             w_gnt1,
  output logic             w_sout,
  output logic             w_sval,
  output logic             w_sfirst,
  output logic             w_owner,
  output logic             w_busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic             last, owner, gnt0, gnt1;
  logic             accept, pick1;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // On contention, the requester that was not granted last time wins.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    pick1     = 1'b0;
    case (state)
      S_IDLE: begin
        if (w_req0 || w_req1) begin
          accept    = 1'b1;
          pick1     = w_req1 && (!w_req0 || !last);
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_cnt == BIT_LAST) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sreg    <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      last    <= 1'b1;
      owner   <= 1'b0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
    end else begin
      gnt0 <= accept && !pick1;
      gnt1 <= accept && pick1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sreg    <= pick1 ? w_data1 : w_data0;
            owner   <= pick1;
            last    <= pick1;
            bit_cnt <= '0;
            gap_cnt <= '0;
          end
        end
        S_SHIFT: begin
          sreg    <= {1'b0, sreg[WIDTH-1:1]};
          gap_cnt <= '0;
          if (bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + CW'(1);
        end
        S_GAP: begin
          if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign w_gnt0   = gnt0;
  assign w_gnt1   = gnt1;
  assign w_sval   = (state == S_SHIFT);
  assign w_busy   = (state != S_IDLE);
  assign w_sout   = w_sval && sreg[0];
  assign w_sfirst = w_sval && (bit_cnt == '0);
  assign w_owner  = w_sval && owner;

endmodule

// File: tb/tb_m_shift_sched.sv
// Scoreboard bench for m_shift_sched: instance 0 uses GAP=1, instance 1 uses GAP=0.
module tb_m_shift_sched;

  localparam int W = 4;

  typedef struct {
    logic b;
    logic first;
    logic own;
    int   space;
  } bit_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req0, req1;
  logic [W-1:0]  data0 [2];
  logic [W-1:0]  data1 [2];
  logic [1:0]    gnt0, gnt1, sout, sval, sfirst, owner, busy;
  int            gap_cfg [2];

  bit_t bq [2][$];
  int   gq [2][$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_first [2];
  int   gap_run [2];
  logic prev_busy [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m_shift_sched #(.WIDTH(W), .GAP(1)) u_dut0 (
    .w_clk(clk), .w_rst_n(rst_n),
    .w_req0(req0[0]), .w_data0(data0[0]), .w_req1(req1[0]), .w_data1(data1[0]),
    .w_gnt0(gnt0[0]), .w_gnt1(gnt1[0]), .w_sout(sout[0]), .w_sval(sval[0]),
    .w_sfirst(sfirst[0]), .w_owner(owner[0]), .w_busy(busy[0])
  );

  m_shift_sched #(.WIDTH(W), .GAP(0)) u_dut1 (
    .w_clk(clk), .w_rst_n(rst_n),
    .w_req0(req0[1]), .w_data0(data0[1]), .w_req1(req1[1]), .w_data1(data1[1]),
    .w_gnt0(gnt0[1]), .w_gnt1(gnt1[1]), .w_sout(sout[1]), .w_sval(sval[1]),
    .w_sfirst(sfirst[1]), .w_owner(owner[1]), .w_busy(busy[1])
  );

  task automatic chk(input string name, input int k, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0d expected=%0d at t=%0t", name, k, act, exp, $time);
    end
  endtask

  function automatic int outs(input int k);
    return {gnt0[k], gnt1[k], sout[k], sval[k], sfirst[k], owner[k], busy[k]};
  endfunction

  task automatic push_frame(input int k, input int own, input logic [W-1:0] d, input int space);
    gq[k].push_back(own);
    for (int i = 0; i < W; i++)
      bq[k].push_back('{b: d[i], first: (i == 0), own: own[0], space: (i == 0) ? space : -1});
  endtask

  task automatic wait_gnt(input int k, input int who);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if ((who == 0 && gnt0[k]) || (who == 1 && gnt1[k])) return;
    end
    chk("grant_timeout", k, 0, 1);
  endtask

  task automatic wait_idle(input int k);
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (!busy[k]) return;
    end
    chk("idle_timeout", k, 0, 1);
  endtask

  // Monitor: pops expectations whenever a grant or a valid serial bit appears.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_busy[k] = 1'b0;
        gap_run[k]   = 0;
      end else begin
        if (gnt0[k] || gnt1[k]) begin
          if (gq[k].size() == 0) chk("unexpected_grant", k, {gnt1[k], gnt0[k]}, 0);
          else begin
            int g;
            g = gq[k].pop_front();
            chk("grant", k, {gnt1[k], gnt0[k]}, (g == 1) ? 2 : 1);
          end
        end
        if (sval[k]) begin
          if (bq[k].size() == 0) chk("unexpected_bit", k, 1, 0);
          else begin
            bit_t e;
            e = bq[k].pop_front();
            chk("sout", k, sout[k], e.b);
            chk("sfirst", k, sfirst[k], e.first);
            chk("owner", k, owner[k], e.own);
            if (sfirst[k]) begin
              if (e.space >= 0) chk("frame_spacing", k, cyc - last_first[k], e.space);
              last_first[k] = cyc;
            end
          end
        end else begin
          chk("quiet_lane", k, {sout[k], sfirst[k], owner[k]}, 0);
          if (busy[k]) gap_run[k]++;
        end
        if (prev_busy[k] && !busy[k]) chk("gap_len", k, gap_run[k], gap_cfg[k]);
        if (!busy[k]) gap_run[k] = 0;
        prev_busy[k] = busy[k];
      end
    end
  end

  initial begin
    gap_cfg[0] = 1;
    gap_cfg[1] = 0;
    last_first[0] = 0;
    last_first[1] = 0;
    rst_n = 1'b0;
    req0 = 2'b11;
    req1 = 2'b11;
    for (int k = 0; k < 2; k++) begin
      data0[k] = 4'hF;
      data1[k] = 4'hF;
    end

    // Reset held with both requests active
    repeat (3) begin
      @(negedge clk);
      chk("reset_outs", 0, outs(0), 0);
      chk("reset_outs", 1, outs(1), 0);
    end
    @(posedge clk); #1;
    req0 = '0;
    req1 = '0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single frame 1011; data change and a brief req1 during SHIFT must have no effect
    push_frame(0, 0, 4'b1011, -1);
    data0[0] = 4'b1011;
    req0[0] = 1'b1;
    wait_gnt(0, 0);
    req0[0] = 1'b0;
    data0[0] = 4'h0;
    req1[0] = 1'b1;
    @(posedge clk); #1;
    req1[0] = 1'b0;
    wait_idle(0);

    // Lone requester 1, two frames
    push_frame(0, 1, 4'hC, -1);
    push_frame(0, 1, 4'hC, 6);
    data1[0] = 4'hC;
    req1[0] = 1'b1;
    wait_gnt(0, 1);
    wait_gnt(0, 1);
    req1[0] = 1'b0;
    wait_idle(0);

    // Continuous dual requests alternate
    push_frame(0, 0, 4'hA, -1);
    push_frame(0, 1, 4'h5, 6);
    push_frame(0, 0, 4'hA, 6);
    push_frame(0, 1, 4'h5, 6);
    data0[0] = 4'hA;
    data1[0] = 4'h5;
    req0[0] = 1'b1;
    req1[0] = 1'b1;
    wait_gnt(0, 0);
    wait_gnt(0, 1);
    wait_gnt(0, 0);
    wait_gnt(0, 1);
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    wait_idle(0);

    // Reset after two bits of a requester-1 frame
    gq[0].push_back(1);
    bq[0].push_back('{b: 1'b0, first: 1'b1, own: 1'b1, space: -1});
    bq[0].push_back('{b: 1'b1, first: 1'b0, own: 1'b1, space: -1});
    data1[0] = 4'h6;
    req1[0] = 1'b1;
    wait_gnt(0, 1);
    req1[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 0, outs(0), 0);
    @(posedge clk); #1;
    chk("reset_no_gap", 0, outs(0), 0);
    rst_n = 1'b1;

    // After reset the pointer favours requester 0
    push_frame(0, 0, 4'h3, -1);
    push_frame(0, 1, 4'h9, 6);
    data0[0] = 4'h3;
    data1[0] = 4'h9;
    req0[0] = 1'b1;
    req1[0] = 1'b1;
    wait_gnt(0, 0);
    wait_gnt(0, 1);
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    wait_idle(0);

    // GAP=0 instance: back-to-back frames with one idle cycle
    push_frame(1, 0, 4'h9, -1);
    push_frame(1, 0, 4'h9, 5);
    push_frame(1, 0, 4'h9, 5);
    data0[1] = 4'h9;
    req0[1] = 1'b1;
    wait_gnt(1, 0);
    wait_gnt(1, 0);
    wait_gnt(1, 0);
    req0[1] = 1'b0;
    wait_idle(1);

    repeat (5) @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("bits_left", k, bq[k].size(), 0);
      chk("grants_left", k, gq[k].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/m_shift_sched.md
Name: m_shift_sched

Overview:
- Two-requester round-robin scheduler and sequencer for a shared WIDTH-bit parallel-load, serial-out shift register.
- Accepts a parallel word from the granted requester, loads it, and shifts it out LSB first, one bit per clock, with valid/first-bit framing.
- Enforces a programmable idle gap between frames.
- Sits between parallel producers and a single serial output lane.

Parameters:
WIDTH  4  bits per frame; legal range WIDTH >= 2
GAP    1  idle cycles inserted after each frame; legal range 0..15

Ports:
w_clk    in   1      clock, rising edge
w_rst_n  in   1      reset, asynchronous, active-low
w_req0   in   1      requester 0 request; held with w_data0 until w_gnt0 is seen
w_data0  in   WIDTH  requester 0 parallel word
w_req1   in   1      requester 1 request
w_data1  in   WIDTH  requester 1 parallel word
w_gnt0   out  1      one-cycle pulse: requester 0 word accepted
w_gnt1   out  1      one-cycle pulse: requester 1 word accepted
w_sout   out  1      serial data, LSB first
w_sval   out  1      w_sout carries a valid bit
w_sfirst out  1      marks bit 0 of a frame
w_owner  out  1      requester whose frame is on the lane; valid while w_sval=1
w_busy   out  1      high in SHIFT or GAP state

Behaviour:
- Reset: w_rst_n=0 clears all state immediately, independent of w_clk.
  - State=IDLE; shift register=0; bit and gap counters=0; last-grant pointer=1, so requester 0 wins first.
  - All outputs 0 during and after reset until the first acceptance.
  - Reset mid-frame aborts the frame; no further bits, grant or gap.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.
- IDLE:
  - No request: stay in IDLE; all outputs 0.
  - One request: accept it.
  - Both requests: accept the requester that is not the last-grant pointer.
  - Acceptance at a rising edge:
    - load the chosen w_dataN into the shift register;
    - set owner, update the pointer, clear the bit counter;
    - go to SHIFT;
    - w_gntN is high for exactly the following cycle.
- SHIFT:
  - w_sval=1, w_busy=1, w_sout=shift register bit 0.
  - w_sfirst=1 only while the bit counter is 0.
  - Each edge: shift right with 0 fill; bit counter increments.
  - At the edge where the bit counter equals WIDTH-1: go to GAP if GAP>0, otherwise to IDLE.
  - Requests are ignored in SHIFT.
- GAP:
  - w_busy=1; w_sval=0, w_sout=0, w_sfirst=0.
  - Stays for exactly GAP cycles, then goes to IDLE.
- Latency:
  - bit 0 appears in the cycle after the accepting edge, coincident with w_gntN;
  - bit WIDTH-1 appears WIDTH cycles after the accepting edge.
- Frame spacing: IDLE is always occupied for at least one cycle, so the minimum distance between frame-start edges is WIDTH+GAP+1 cycles.
- Round-robin: a lone requester is granted every frame. Under continuous dual requests, grants strictly alternate.
- Request withdrawn before acceptance: no grant, no frame.
- w_dataN is sampled only at the accepting edge; later changes have no effect.
- Bit and gap counter widths: $clog2(WIDTH) and 4 bits; neither counter may wrap.

Test Plan:
- Reset: hold w_rst_n=0 for 3 cycles with w_req0=w_req1=1 -> all outputs 0. Assert w_rst_n=0 asynchronously between edges -> outputs clear before the next edge.
- WIDTH=4, GAP=1; w_req0=1, w_data0=4'b1011 -> w_gnt0 high 1 cycle; w_sout=1,1,0,1 on 4 consecutive w_sval cycles; w_sfirst on the first only; w_owner=0. Then 1 cycle w_busy=1, w_sval=0, then IDLE.
- Both requests held continuously, w_data0=4'hA, w_data1=4'h5 -> grant order 0,1,0,1. Serial streams 0,1,0,1 then 1,0,1,0. Frame starts 6 cycles apart.
- Only w_req1 held for two frames, w_data1=4'hC -> both frames owned by requester 1; w_sout=0,0,1,1 twice.
- Reset pulse after 2 bits of a requester-1 frame -> outputs 0 at once, no gap. After release, with both requests, requester 0 is granted first.
- GAP=0, w_req0 continuous -> frames back-to-back with one IDLE cycle; frame starts 5 cycles apart; w_busy low exactly 1 cycle between frames.
